softmax_row_max: RTL and testbench

- Streaming reducer that produces the per-row maximum consumed as the common subtrahend by the softmax subtract stage, which computes x - max on four lanes.
- Accepts one attention-score row as NUM_BEATS beats of four fp16 lanes.
- Reduces the row to a single maximum and presents it through a valid/ready handshake.
- Sits between the score-producing stage and the four-lane subtract stage.

---
 rtl/softmax_row_max.sv | 165 ++++++++++++++++
 tb/tb_softmax_row_max.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_row_max.sv
// Row-maximum reducer for the softmax subtract stage.
// Four fp16 lanes per beat, NUM_BEATS beats per row, valid/ready out.
`timescale 1ns/1ps
module softmax_row_max #(
  parameter int DATAWIDTH = 16,
  parameter int NUM_BEATS = 8,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] a_inp0,
  input  logic [DATAWIDTH-1:0] a_inp1,
  input  logic [DATAWIDTH-1:0] a_inp2,
  input  logic [DATAWIDTH-1:0] a_inp3,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] max_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                 w_acc;
  logic                 w_first;
  logic                 w_last;
  logic [CNT_W-1:0]     r_cnt;

  logic [3:0][DATAWIDTH-1:0] r_s0_lane;
  logic                 r_s0_valid;
  logic                 r_s0_first;
  logic                 r_s0_last;

  logic [DATAWIDTH-1:0] r_s1_max;
  logic                 r_s1_valid;
  logic                 r_s1_first;
  logic                 r_s1_last;

  logic [DATAWIDTH-1:0] r_run;
  logic [DATAWIDTH-1:0] r_max;
  logic                 r_out_valid;

  logic [DATAWIDTH-1:0] w_m01;
  logic [DATAWIDTH-1:0] w_m23;
  logic [DATAWIDTH-1:0] w_m;
  logic [DATAWIDTH-1:0] w_run_nxt;
  logic                 w_s2_load;

  // Sign-magnitude to unsigned order: +0 lands just above -0.
  function automatic logic [DATAWIDTH-1:0] f_key(
    input logic [DATAWIDTH-1:0] x
  );
    return x[DATAWIDTH-1] ? ~x :
      (x | {1'b1, {(DATAWIDTH-1){1'b0}}});
  endfunction

  // Strict compare: ties keep the earlier lane/beat.
  function automatic logic f_gt(
    input logic [DATAWIDTH-1:0] a,
    input logic [DATAWIDTH-1:0] b
  );
    return f_key(a) > f_key(b);
  endfunction

  assign in_ready = (r_state == IDLE) ||
                    (r_state == ACCUM);
  assign w_acc    = in_valid & in_ready;
  assign w_first  = (r_cnt == '0);
  assign w_last   = (r_cnt == CNT_W'(NUM_BEATS-1));
  assign busy     = (r_state != IDLE);
  assign max_out  = r_max;
  assign out_valid = r_out_valid;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (w_acc) w_next = w_last ? FLUSH : ACCUM;
      ACCUM: if (w_acc && w_last) w_next = FLUSH;
      FLUSH: if (w_s2_load) w_next = DONE;
      DONE:  if (out_ready) w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc)
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      else if (r_state == IDLE)
        r_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s0_lane  <= '0;
      r_s0_valid <= 1'b0;
      r_s0_first <= 1'b0;
      r_s0_last  <= 1'b0;
    end else begin
      r_s0_valid <= w_acc;
      if (w_acc) begin
        r_s0_lane  <= {a_inp3, a_inp2, a_inp1, a_inp0};
        r_s0_first <= w_first;
        r_s0_last  <= w_last;
      end
    end
  end

  assign w_m01 = f_gt(r_s0_lane[1], r_s0_lane[0]) ?
                 r_s0_lane[1] : r_s0_lane[0];
  assign w_m23 = f_gt(r_s0_lane[3], r_s0_lane[2]) ?
                 r_s0_lane[3] : r_s0_lane[2];
  assign w_m   = f_gt(w_m23, w_m01) ? w_m23 : w_m01;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_max   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= r_s0_valid;
      if (r_s0_valid) begin
        r_s1_max   <= w_m;
        r_s1_first <= r_s0_first;
        r_s1_last  <= r_s0_last;
      end
    end
  end

  assign w_run_nxt = (r_s1_first || f_gt(r_s1_max, r_run)) ?
                     r_s1_max : r_run;
  assign w_s2_load = r_s1_valid & r_s1_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run       <= '0;
      r_max       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_s1_valid)
        r_run <= w_run_nxt;
      if (w_s2_load) begin
        r_max       <= w_run_nxt;
        r_out_valid <= 1'b1;
      end else if (r_state == DONE && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_softmax_row_max.sv
// Bench for softmax_row_max: scoreboard of row maxima from a
// real-valued fp16 model, plus latency, hold and reset checks.
`timescale 1ns/1ps
module tb_softmax_row_max;

  localparam int NB = 8;
  localparam int NW = NB * 4;
  typedef logic [15:0] row_t [NW];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a_inp0 = '0;
  logic [15:0] a_inp1 = '0;
  logic [15:0] a_inp2 = '0;
  logic [15:0] a_inp3 = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] max_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  softmax_row_max #(
    .DATAWIDTH(16),
    .NUM_BEATS(NB),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .a_inp0(a_inp0),
    .a_inp1(a_inp1),
    .a_inp2(a_inp2),
    .a_inp3(a_inp3),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .max_out(max_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
  );

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic real f2r(input logic [15:0] x);
    int  e;
    int  sh;
    real v;
    e = int'(x[14:10]);
    if (e == 31) begin
      v = 1.0e30;
    end else begin
      if (e == 0) begin
        v  = real'(int'(x[9:0]));
        sh = -24;
      end else begin
        v  = real'(int'(x[9:0]) + 1024);
        sh = e - 25;
      end
      while (sh > 0) begin v = v * 2.0; sh--; end
      while (sh < 0) begin v = v / 2.0; sh++; end
    end
    return x[15] ? -v : v;
  endfunction

  // Largest value in row order; +0 outranks -0.
  function automatic logic [15:0] ref_max(input row_t r);
    logic [15:0] best;
    real         bv;
    real         v;
    best = r[0];
    bv   = f2r(r[0]);
    for (int i = 1; i < NW; i++) begin
      v = f2r(r[i]);
      if (v > bv ||
          (v == bv && best == 16'h8000 && r[i] == 16'h0000)) begin
        best = r[i];
        bv   = v;
      end
    end
    return best;
  endfunction

  function automatic logic [15:0] neg_int(input int n);
    int k;
    int m;
    k = 0;
    while ((2 << k) <= n) k++;
    m = (n - (1 << k)) << (10 - k);
    return {1'b1, 5'(k + 15), 10'(m)};
  endfunction

  function automatic logic [15:0] rnd_h();
    logic [15:0] x;
    logic [15:0] pool [6];
    pool = '{16'h0000, 16'h8000, 16'h7C00,
             16'hFC00, 16'h3C00, 16'hBC00};
    if ($urandom_range(3) == 0)
      return pool[$urandom_range(5)];
    do begin
      x = 16'($urandom);
    end while (x[14:10] == 5'h1F && x[9:0] != 10'h0);
    return x;
  endfunction

  task automatic send_row(input row_t r, input int gap,
                          input int hold, input string tag);
    logic [15:0] e;
    int          guard;
    e = ref_max(r);
    out_ready = (hold == 0);
    for (int b = 0; b < NB; b++) begin
      while (int'($urandom_range(99)) < gap) begin
        in_valid = 1'b0;
        step();
      end
      a_inp0   = r[b*4];
      a_inp1   = r[b*4+1];
      a_inp2   = r[b*4+2];
      a_inp3   = r[b*4+3];
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 200) begin
        step();
        guard++;
      end
      if (guard >= 200) begin
        checks++;
        failures++;
        $display("FAIL %s_in_ready: got 0 want 1", tag);
        in_valid = 1'b0;
        return;
      end
      if (b == NB-1) exp_q.push_back(e);
      step();
    end
    in_valid = 1'b0;
    chk({tag, "_lat0"}, 16'(out_valid), 16'd0);
    step();
    chk({tag, "_lat1"}, 16'(out_valid), 16'd0);
    step();
    chk({tag, "_lat2"}, 16'(out_valid), 16'd1);
    chk({tag, "_busy"}, 16'(busy), 16'd1);
    for (int i = 0; i < hold; i++) begin
      a_inp0   = 16'h7C00;
      a_inp1   = 16'h7C00;
      a_inp2   = 16'h7C00;
      a_inp3   = 16'h7C00;
      in_valid = 1'b1;
      step();
      chk({tag, "_hold_v"}, 16'(out_valid), 16'd1);
      chk({tag, "_hold_max"}, max_out, e);
      chk({tag, "_hold_rdy"}, 16'(in_ready), 16'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk({tag, "_busy_fall"}, 16'(busy), 16'd0);
    chk({tag, "_ov_fall"}, 16'(out_valid), 16'd0);
    chk({tag, "_rdy_back"}, 16'(in_ready), 16'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got %h want none",
                   max_out);
        end else begin
          chk("row_max", max_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t r;

    rst = 1'b0;
    step();
    step();
    chk("rst_ov", 16'(out_valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_rdy", 16'(in_ready), 16'd1);
    chk("rst_max", max_out, 16'h0000);
    rst = 1'b1;
    step();

    foreach (r[i]) r[i] = 16'h3C00;
    r[5*4+2] = 16'h5640;
    send_row(r, 0, 0, "t1");

    foreach (r[i]) r[i] = neg_int(i + 1);
    send_row(r, 0, 0, "t2_neg");

    foreach (r[i]) r[i] = (i % 3 == 0) ? 16'h8000 : 16'h0000;
    send_row(r, 0, 0, "t3_mix0");
    foreach (r[i]) r[i] = 16'h8000;
    send_row(r, 0, 0, "t3_neg0");

    foreach (r[i]) r[i] = 16'h3C00;
    r[5*4+2] = 16'h5640;
    send_row(r, 0, 5, "t4_hold");
    foreach (r[i]) r[i] = 16'hC000;
    send_row(r, 0, 0, "t4_next");

    foreach (r[i]) r[i] = 16'h3C00;
    r[5*4+2] = 16'h5640;
    send_row(r, 50, 0, "t5_gap");

    foreach (r[i]) r[i] = 16'h3C00;
    r[1] = 16'h7BFF;
    r[9] = 16'h7BFF;
    for (int b = 0; b < 3; b++) begin
      a_inp0   = r[b*4];
      a_inp1   = r[b*4+1];
      a_inp2   = r[b*4+2];
      a_inp3   = r[b*4+3];
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_ov", 16'(out_valid), 16'd0);
    chk("t6_busy", 16'(busy), 16'd0);
    chk("t6_rdy", 16'(in_ready), 16'd1);
    chk("t6_max", max_out, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_quiet", 16'(out_valid), 16'd0);
    end
    foreach (r[i]) r[i] = 16'h3C00;
    r[17] = 16'h4000;
    send_row(r, 0, 0, "t6_fresh");

    for (int n = 0; n < 20; n++) begin
      foreach (r[i]) r[i] = rnd_h();
      send_row(r, int'($urandom_range(60)),
               int'($urandom_range(3)), "rand");
    end

    step();
    step();
    chk("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
